// File: rtl/spi_rr_packet_arbiter.sv
// Round-robin, packet-locking arbiter sharing one val/rdy SPI response path.
// Optional stall timeout (timeout_err output) is built when ARB_TIMEOUT_EN is defined.
module spi_rr_packet_arbiter #(
  parameter int unsigned nbits      = 32,
  parameter int unsigned num_inputs = 4,
  parameter int unsigned addr_nbits = $clog2(num_inputs),
  parameter int unsigned pkt_beats  = 4
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int unsigned timeout_cycles = 64
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_val [num_inputs],
  output logic                        req_rdy [num_inputs],
  input  logic [nbits-1:0]            req_msg [num_inputs],
  output logic                        resp_val,
  input  logic                        resp_rdy,
  output logic [addr_nbits+nbits-1:0] resp_msg,
  output logic [addr_nbits-1:0]       grant_idx,
  output logic                        busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                        timeout_err
`endif
);

  localparam int unsigned CNT_W = $clog2(pkt_beats + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [addr_nbits-1:0]  lock_idx_q, lock_idx_d;
  logic [addr_nbits-1:0]  last_idx_q, last_idx_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [addr_nbits-1:0]  pick;
  logic [addr_nbits-1:0]  sel;
  logic                   pick_found;
  logic                   active;
  logic                   xfer;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(timeout_cycles + 1);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               timeout_err_q, timeout_err_d;

  assign timeout_err = timeout_err_q;
`endif

  // First valid requester after last_idx, wrapping around.
  always_comb begin : pick_search
    int unsigned idx;
    idx        = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int unsigned i = 1; i <= num_inputs; i++) begin
      idx = (32'(last_idx_q) + i) % num_inputs;
      if (!pick_found && req_val[addr_nbits'(idx)]) begin
        pick       = addr_nbits'(idx);
        pick_found = 1'b1;
      end
    end
  end

  // Response mux: locked owner, else the live pick; everything quiet in reset.
  always_comb begin
    sel = (state_q == LOCKED) ? lock_idx_q : pick;
    if (reset) begin
      sel = '0;
    end
    active    = !reset && ((state_q == LOCKED) || pick_found);
    grant_idx = sel;
    resp_val  = active && req_val[sel];
    resp_msg  = {sel, req_msg[sel]};
    busy      = (state_q == LOCKED);
    for (int unsigned i = 0; i < num_inputs; i++) begin
      req_rdy[i] = active && resp_rdy && (sel == addr_nbits'(i));
    end
  end

  assign xfer = resp_val && resp_rdy;

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    last_idx_d = last_idx_q;
    beat_cnt_d = beat_cnt_q;
`ifdef ARB_TIMEOUT_EN
    stall_cnt_d   = stall_cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A stalled first beat also locks, keeping resp_msg stable until accepted.
        if (resp_val) begin
`ifdef ARB_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
          if (resp_rdy && (pkt_beats == 1)) begin
            last_idx_d = pick;
          end else begin
            state_d    = LOCKED;
            lock_idx_d = pick;
            beat_cnt_d = resp_rdy ? CNT_W'(1) : '0;
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
`ifdef ARB_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
          if (beat_cnt_q == CNT_W'(pkt_beats - 1)) begin
            state_d    = IDLE;
            last_idx_d = lock_idx_q;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (stall_cnt_q == STALL_W'(timeout_cycles - 1)) begin
          state_d       = IDLE;
          last_idx_d    = lock_idx_q;
          beat_cnt_d    = '0;
          stall_cnt_d   = '0;
          timeout_err_d = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      last_idx_q <= addr_nbits'(num_inputs - 1);
      beat_cnt_q <= '0;
`ifdef ARB_TIMEOUT_EN
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      last_idx_q <= last_idx_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef ARB_TIMEOUT_EN
      stall_cnt_q   <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

endmodule
